vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Owns the single-port frame-buffer RAM and shares it between three requesters:
  - the VGA driver's pixel fetch (VGA_request/xpos/ypos, one clock ahead of display),
  - a buffered game-logic pixel write port,
  - a hardware full-screen clear engine.
- Fixed priority: display read > clear > buffered write.
- Frame buffer is stored downscaled by 2^SCALE_SHIFT in both axes. Display coordinates are shifted before addressing.
- Sits between the game logic and the VGA driver. The RAM itself stays external.

Parameters:
- H_RES, 640, displayed width in pixels
- V_RES, 480, displayed height in pixels
- SCALE_SHIFT, 2, downscale shift; FB_W = H_RES>>SCALE_SHIFT (160), FB_H = V_RES>>SCALE_SHIFT (120)
- ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= FB_W*FB_H
- FIFO_DEPTH, 16, write FIFO entries (power of two)

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  reset
- vga_request  in  1  display fetch request from VGA driver
- vga_xpos  in  11  display x (valid with vga_request)
- vga_ypos  in  11  display y (valid with vga_request)
- vga_data  out  12  pixel to VGA driver, {R,B,G} 4 bits each
- wr_valid  in  1  game write request
- wr_ready  out  1  write FIFO can accept
- wr_x  in  11  frame-buffer x, 0..FB_W-1
- wr_y  in  11  frame-buffer y, 0..FB_H-1
- wr_color  in  12  pixel colour
- clr_start  in  1  single-cycle pulse: start full clear
- clr_color  in  12  clear colour, sampled on accepted clr_start
- clr_busy  out  1  clear in progress
- wr_err  out  1  sticky: an out-of-range write was dropped
- mem_addr  out  ADDR_W  RAM address (combinational)
- mem_we  out  1  RAM write enable
- mem_wdata  out  12  RAM write data
- mem_rdata  in  12  RAM read data, synchronous, 1-cycle latency

Interface: one clock, clk. Reset rst_n is asynchronous, active-low.

Behaviour:
- Reset values:
  - vga_data = 0, clr_busy = 0, wr_err = 0, mem_we = 0.
  - wr_ready = 1.
  - FIFO empty, clear counter 0, rd_pending = 0.
- Address:
  - addr(x,y) = y*FB_W + x, truncated to ADDR_W.
  - Display address uses x = vga_xpos>>SCALE_SHIFT and y = vga_ypos>>SCALE_SHIFT.
- Per-cycle port grant:
  1. If vga_request=1: mem_addr = display address, mem_we = 0, rd_pending <= 1.
  2. Else if clr_busy: mem_addr = clr_cnt, mem_we = 1, mem_wdata = clr_color_reg; clr_cnt increments.
  3. Else if FIFO non-empty: mem_addr and mem_wdata from FIFO head, mem_we = 1, pop.
  4. Else: mem_we = 0, mem_addr = 0.
- Display path:
  - Latency is exactly 1 cycle: vga_data = rd_pending ? mem_rdata : 0.
  - rd_pending is vga_request delayed one cycle.
  - Display is never stalled.
- Write port:
  - Push when wr_valid && wr_ready; wr_ready = !fifo_full.
  - Range check at push: if wr_x >= FB_W or wr_y >= FB_H, the handshake still completes but the entry is not pushed and wr_err is set.
  - Simultaneous push and pop on a full FIFO: wr_ready is 0, so no push occurs.
  - Simultaneous push and pop on a non-full FIFO: both occur, count unchanged.
  - The FIFO does not drain while clr_busy=1. Pushes are still accepted until full.
- Clear FSM, states IDLE and CLEAR:
  - IDLE→CLEAR on clr_start: latch clr_color, clr_cnt <= 0, clr_busy <= 1, wr_err <= 0.
  - CLEAR→IDLE on the granted write with clr_cnt == FB_W*FB_H-1; clr_busy <= 0 the next cycle.
  - clr_start while in CLEAR is ignored.
  - The clear only advances on cycles not taken by display.
- wr_err clears only on an accepted clr_start or on reset.
- Asynchronous reset mid-clear or mid-drain:
  - Immediately returns to IDLE with an empty FIFO.
  - Pending FIFO entries are discarded.
- Order of write effects:
  - Writes queued before a clr_start land after the clear completes and survive it.

Decomposition:
- Shared package vga_pkg:
  - constants H_RES, V_RES, SCALE_SHIFT, FB_W, FB_H, FB_PIXELS, ADDR_W,
  - pixel colour type (12-bit {R,B,G}) and clear-state enum.
- Sub-module vga_wr_fifo:
  - synchronous FIFO of {addr[ADDR_W], color[12]}, FIFO_DEPTH entries,
  - outputs full/empty, show-ahead head.
- Address multiply stays in the top. For FB_W=160 it can be a constant multiply or shift-add.

Test Plan:
- Display latency:
  - Preload RAM addr 161 = 12'hF00.
  - Set vga_request=1, xpos=4..7, ypos=4..7 (fb x=1, y=1).
  - Required: mem_addr=161, mem_we=0 in the same cycle; vga_data=12'hF00 in the next cycle; vga_data=0 the cycle after vga_request drops.
- Write in blanking:
  - vga_request=0, push (x=3, y=2, 12'h0F0).
  - Required: RAM addr 323 written within 2 cycles; wr_ready stays 1.
- Write during active line:
  - Hold vga_request=1 for 640 cycles, push 20 writes.
  - Required: wr_ready drops after 16 accepted; zero mem_we while requested; all 16 land in order once request drops, then the remaining 4 are accepted and written.
- Out-of-range:
  - Push x=160, y=0.
  - Required: handshake completes, no RAM write, wr_err=1 and stays 1 until the next clr_start.
- Clear:
  - clr_start with clr_color=12'h00F, vga_request toggling 50%.
  - Required: clr_busy high until all 19200 addresses are written with 12'h00F; a second clr_start mid-clear is ignored; a write queued before clr_start lands after clr_busy falls.
- Reset mid-clear:
  - Assert rst_n=0 at clr_cnt=5000 with 3 FIFO entries queued.
  - Required: clr_busy=0, wr_ready=1, mem_we=0 immediately; no further writes after release.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: frame-buffer geometry, pixel type and clear-engine states
package vga_pkg;
  localparam int H_RES       = 640;
  localparam int V_RES       = 480;
  localparam int SCALE_SHIFT = 2;
  localparam int FB_W        = H_RES >> SCALE_SHIFT;
  localparam int FB_H        = V_RES >> SCALE_SHIFT;
  localparam int FB_PIXELS   = FB_W * FB_H;
  localparam int ADDR_W      = 15;
  localparam int FIFO_DEPTH  = 16;
  typedef logic [11:0] pixel_t;
  typedef enum logic {CLR_IDLE, CLR_CLEAR} clr_state_t;
endpackage

// File: rtl/vga_wr_fifo.sv
// vga_wr_fifo: show-ahead FIFO of pending frame-buffer pixel writes
module vga_wr_fifo
  import vga_pkg::*;
#(
  parameter int AW    = ADDR_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  pixel_t        push_color,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] head_addr,
  output pixel_t        head_color
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW+11:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign {head_addr, head_color} = mem[rd_ptr];
  // entry storage; occupancy decides what is visible, so no reset needed
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= {push_addr, push_color};
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares the frame-buffer RAM between display fetch, clear engine and buffered writes
module vga_fb_arbiter
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_request,
  input  logic [10:0]       vga_xpos,
  input  logic [10:0]       vga_ypos,
  output pixel_t            vga_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [10:0]       wr_x,
  input  logic [10:0]       wr_y,
  input  pixel_t            wr_color,
  input  logic              clr_start,
  input  pixel_t            clr_color,
  output logic              clr_busy,
  output logic              wr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output pixel_t            mem_wdata,
  input  pixel_t            mem_rdata
);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_PIXELS - 1);
  clr_state_t state;
  logic [ADDR_W-1:0] clr_cnt, disp_addr, push_addr, head_addr;
  pixel_t clr_color_reg, head_color;
  logic rd_pending, full, empty, in_range, push, pop, bad_wr, clr_go, clr_accept;

  function automatic logic [ADDR_W-1:0] fb_addr(input logic [10:0] x, input logic [10:0] y);
    return ADDR_W'(32'(y) * FB_W + 32'(x));
  endfunction

  assign disp_addr = fb_addr(vga_xpos >> SCALE_SHIFT, vga_ypos >> SCALE_SHIFT);
  assign push_addr = fb_addr(wr_x, wr_y);
  assign in_range = 32'(wr_x) < FB_W && 32'(wr_y) < FB_H;
  assign wr_ready = !full;
  assign push = wr_valid && wr_ready && in_range;
  assign bad_wr = wr_valid && wr_ready && !in_range;
  assign clr_busy = state == CLR_CLEAR;
  assign clr_accept = clr_start && !clr_busy;
  assign clr_go = !vga_request && clr_busy;
  assign pop = !vga_request && !clr_busy && !empty;
  assign mem_we = clr_go || pop;
  assign mem_addr = vga_request ? disp_addr : clr_busy ? clr_cnt : pop ? head_addr : '0;
  assign mem_wdata = clr_go ? clr_color_reg : pop ? head_color : '0;
  assign vga_data = rd_pending ? mem_rdata : '0;

  vga_wr_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_addr  (push_addr),
    .push_color (wr_color),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .head_addr  (head_addr),
    .head_color (head_color)
  );

  // marks that the RAM output next cycle belongs to the display
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_pending <= 1'b0;
    else rd_pending <= vga_request;

  // clear engine sweeps every frame-buffer address on cycles the display leaves free
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= CLR_IDLE;
      clr_cnt       <= '0;
      clr_color_reg <= '0;
    end else if (clr_accept) begin
      state         <= CLR_CLEAR;
      clr_cnt       <= '0;
      clr_color_reg <= clr_color;
    end else if (clr_go) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == CLR_LAST) state <= CLR_IDLE;
    end

  // sticky flag for dropped out-of-range writes, cleared by starting a new clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wr_err <= 1'b0;
    else if (bad_wr) wr_err <= 1'b1;
    else if (clr_accept) wr_err <= 1'b0;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: randomized bench checked against a frame-buffer scoreboard and write log
module tb_vga_fb_arbiter;
  import vga_pkg::*;
  logic clk = 0, rst_n = 0;
  logic vga_request = 0;
  logic [10:0] vga_xpos = 0, vga_ypos = 0;
  logic [11:0] vga_data;
  logic wr_valid = 0, wr_ready;
  logic [10:0] wr_x = 0, wr_y = 0;
  logic [11:0] wr_color = 0;
  logic clr_start = 0;
  logic [11:0] clr_color = 0;
  logic clr_busy, wr_err;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_we;
  logic [11:0] mem_wdata, mem_rdata;
  logic [11:0] ram [1<<ADDR_W];
  logic [11:0] fb_exp [FB_PIXELS];
  typedef struct {int a; int d;} wr_t;
  wr_t wlog[$];
  int n_tests = 0, n_fail = 0, bad_we = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_request (vga_request),
    .vga_xpos    (vga_xpos),
    .vga_ypos    (vga_ypos),
    .vga_data    (vga_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_color    (wr_color),
    .clr_start   (clr_start),
    .clr_color   (clr_color),
    .clr_busy    (clr_busy),
    .wr_err      (wr_err),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // external single-port RAM with 1-cycle read latency, plus a log of every write
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wlog.push_back('{int'(mem_addr), int'(mem_wdata)});
      if (vga_request) bad_we++;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int fb_idx(input int x, input int y);
    return y * FB_W + x;
  endfunction

  initial begin
    int prev_a, idx, rdy, errs, x, y, done;
    logic [11:0] c;
    int ix[20], iy[20];
    logic [11:0] ic[20];
    for (int i = 0; i < FB_PIXELS; i++) begin
      c = 12'($urandom);
      ram[i] = c;
      fb_exp[i] = c;
    end
    ram[161] = 12'hF00;
    fb_exp[161] = 12'hF00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vga_data", vga_data, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_wr_ready", wr_ready, 1);
    rst_n = 1;
    tick();
    vga_xpos = 11'(4 + $urandom_range(0, 3));
    vga_ypos = 11'(4 + $urandom_range(0, 3));
    vga_request = 1;
    @(negedge clk);
    check("lat_addr", mem_addr, 161);
    check("lat_we", mem_we, 0);
    tick();
    vga_request = 0;
    @(negedge clk);
    check("lat_data", vga_data, 12'hF00);
    tick();
    @(negedge clk);
    check("lat_drop", vga_data, 0);
    tick();
    wlog.delete();
    wr_x = 3; wr_y = 2; wr_color = 12'h0F0; wr_valid = 1;
    @(negedge clk);
    check("blank_ready", wr_ready, 1);
    tick();
    wr_valid = 0;
    @(negedge clk);
    check("blank_ready_after", wr_ready, 1);
    tick();
    tick();
    check("blank_nwr", wlog.size(), 1);
    check("blank_addr", wlog[0].a, 323);
    check("blank_ram", ram[323], 12'h0F0);
    fb_exp[323] = 12'h0F0;
    wlog.delete();
    wr_x = 160; wr_y = 0; wr_color = 12'hFFF; wr_valid = 1;
    @(negedge clk);
    check("oor_ready", wr_ready, 1);
    tick();
    wr_x = 0; wr_y = 120;
    @(negedge clk);
    check("oor_err", wr_err, 1);
    tick();
    wr_valid = 0;
    repeat (4) tick();
    check("oor_nwr", wlog.size(), 0);
    check("oor_err_hold", wr_err, 1);
    for (int i = 0; i < 20; i++) begin
      ix[i] = $urandom_range(0, FB_W - 1);
      iy[i] = $urandom_range(0, FB_H - 1);
      ic[i] = 12'($urandom);
    end
    wlog.delete();
    idx = 0;
    prev_a = -1;
    for (int k = 0; k < 640; k++) begin
      x = $urandom_range(0, H_RES - 1);
      y = $urandom_range(0, V_RES - 1);
      vga_request = 1; vga_xpos = 11'(x); vga_ypos = 11'(y);
      wr_valid = idx < 20;
      if (idx < 20) begin
        wr_x = 11'(ix[idx]); wr_y = 11'(iy[idx]); wr_color = ic[idx];
      end
      @(negedge clk);
      if (prev_a >= 0) check("disp_active", vga_data, fb_exp[prev_a]);
      rdy = int'(wr_ready);
      tick();
      if (wr_valid && rdy != 0) idx++;
      prev_a = fb_idx(x >> SCALE_SHIFT, y >> SCALE_SHIFT);
    end
    check("act_accepted", idx, 16);
    check("act_ready", wr_ready, 0);
    check("act_nwr", wlog.size(), 0);
    vga_request = 0;
    for (int k = 0; k < 100 && idx < 20; k++) begin
      wr_valid = 1; wr_x = 11'(ix[idx]); wr_y = 11'(iy[idx]); wr_color = ic[idx];
      @(negedge clk);
      rdy = int'(wr_ready);
      tick();
      if (rdy != 0) idx++;
    end
    wr_valid = 0;
    check("act_all_accepted", idx, 20);
    repeat (30) tick();
    check("act_nwr_after", wlog.size(), 20);
    errs = 0;
    for (int i = 0; i < 20; i++)
      if (i >= wlog.size() || wlog[i].a != fb_idx(ix[i], iy[i]) || wlog[i].d != int'(ic[i])) errs++;
    check("act_order", errs, 0);
    for (int i = 0; i < 20; i++) fb_exp[fb_idx(ix[i], iy[i])] = ic[i];
    check("oor_err_still", wr_err, 1);
    wlog.delete();
    x = $urandom_range(0, FB_W - 1);
    y = $urandom_range(0, FB_H - 1);
    c = 12'($urandom);
    vga_request = 1; vga_xpos = 0; vga_ypos = 0;
    wr_valid = 1; wr_x = 11'(x); wr_y = 11'(y); wr_color = c;
    tick();
    wr_valid = 0; clr_start = 1; clr_color = 12'h00F;
    tick();
    clr_start = 0; clr_color = 12'h5A5;
    check("clr_busy_start", clr_busy, 1);
    check("clr_err_cleared", wr_err, 0);
    done = 0;
    for (int k = 0; k < 60000 && done == 0; k++) begin
      vga_request = 1'($urandom_range(0, 1));
      vga_xpos = 11'($urandom_range(0, H_RES - 1));
      vga_ypos = 11'($urandom_range(0, V_RES - 1));
      if (k == 1000) begin clr_start = 1; clr_color = 12'hABC; end
      tick();
      clr_start = 0;
      if (!clr_busy) done = 1;
    end
    check("clr_done", done, 1);
    check("clr_nwr_at_fall", wlog.size(), FB_PIXELS);
    vga_request = 0;
    repeat (5) tick();
    errs = 0;
    for (int i = 0; i < FB_PIXELS; i++)
      if (i >= wlog.size() || wlog[i].a != i || wlog[i].d != 'h00F) errs++;
    check("clr_sweep", errs, 0);
    check("clr_then_wr_n", wlog.size(), FB_PIXELS + 1);
    check("clr_then_wr_addr", wlog[FB_PIXELS].a, fb_idx(x, y));
    check("clr_then_wr_data", wlog[FB_PIXELS].d, int'(c));
    for (int i = 0; i < FB_PIXELS; i++) fb_exp[i] = 12'h00F;
    fb_exp[fb_idx(x, y)] = c;
    errs = 0;
    for (int i = 0; i < FB_PIXELS; i++) if (ram[i] !== fb_exp[i]) errs++;
    check("fb_after_clr", errs, 0);
    wlog.delete();
    vga_request = 1; wr_valid = 1;
    for (int i = 0; i < 3; i++) begin
      wr_x = 11'($urandom_range(0, FB_W - 1));
      wr_y = 11'($urandom_range(0, FB_H - 1));
      wr_color = 12'($urandom);
      tick();
    end
    wr_valid = 0; clr_start = 1; clr_color = 12'h123;
    tick();
    clr_start = 0; vga_request = 0;
    for (int k = 0; k < 20000 && wlog.size() < 5000; k++) tick();
    check("rst_reach", wlog.size(), 5000);
    #2 rst_n = 0;
    #1;
    check("rst_mid_busy", clr_busy, 0);
    check("rst_mid_ready", wr_ready, 1);
    check("rst_mid_we", mem_we, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (50) tick();
    check("rst_no_writes", wlog.size(), 5000);
    check("rst_vga_idle", vga_data, 0);
    check("we_during_req", bad_we, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
